// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Owns the PC, issues one outstanding
//            word read to instruction memory at a time, and buffers returned
//            words in a prefetch FIFO that the decoder drains. A taken branch
//            flushes the FIFO and redirects the PC.
//            Optional macro FETCH_PERF_EN adds push/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                INSTR_W  = 49,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed
`endif
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam int             CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic [ADDR_W-1:0]   fetch_addr;

    logic [INSTR_W-1:0]  data_q [DEPTH];
    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    count;

    logic                push, pop, in_flight;

    assign imem_req    = (state == S_REQ);
    assign imem_addr   = pc;
    assign instr_valid = (count != '0);
    assign instr       = data_q[rd_ptr];
    assign instr_pc    = addr_q[rd_ptr];

    assign pop  = instr_valid && instr_ready;
    assign push = (state == S_WAIT) && imem_rvalid && !branch_taken;

    // A response will still be owed by memory after this edge; a branch
    // must then park in DRAIN to swallow it.
    assign in_flight = ((state == S_REQ) && imem_gnt) ||
                       (((state == S_WAIT) || (state == S_DRAIN)) && !imem_rvalid);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            S_IDLE:  if (count < FULL_CNT) state_nxt = S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    pc_nxt    = pc + ADDR_W'(1);
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT:  if (imem_rvalid) state_nxt = S_IDLE;
            S_DRAIN: if (imem_rvalid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (branch_taken) begin
            pc_nxt    = branch_target;
            state_nxt = in_flight ? S_DRAIN : S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            fetch_addr <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if ((state == S_REQ) && imem_gnt) fetch_addr <= pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else if (branch_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= imem_rdata;
                addr_q[wr_ptr] <= fetch_addr;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push)         perf_fetched <= perf_fetched + 32'd1;
            if (branch_taken) perf_flushed <= perf_flushed + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Testbench for fetch_unit: memory model + scoreboard of granted PCs,
// a table of branch scenarios and hand-written stall / reset sequences.
module tb_fetch_unit;
    localparam int INSTR_W = 49;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt    = 1'b0;
    logic               imem_rvalid = 1'b0;
    logic [INSTR_W-1:0] imem_rdata  = '0;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready = 1'b1;
    logic               branch_taken = 1'b0;
    logic [ADDR_W-1:0]  branch_target = '0;
`ifdef FETCH_PERF_EN
    logic [31:0]        perf_fetched, perf_flushed;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .branch_taken(branch_taken), .branch_target(branch_target)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // memory model state
    int          gnt_lat = 0, rv_lat = 1, gnt_budget = -1;
    int          gw_cnt = 0, rv_cnt = 0;
    bit          busy = 1'b0;
    logic [31:0] resp_addr = '0;

    // scoreboard
    logic [31:0] exp_req_addr = '0;
    logic [31:0] sbq[$];
    logic [31:0] gnt_log[$];
    logic [31:0] pop_log[$];
    int          stale_cnt = 0;

    function automatic logic [INSTR_W-1:0] word(input logic [31:0] a);
        return {a[16:0] ^ 17'h15A5A, a ^ 32'hC0DE_1234};
    endfunction

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory responder and output monitor; inputs change here, between edges.
    always @(negedge clk) begin : model
        logic [31:0] e;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        if (rst) begin
            busy = 1'b0; gw_cnt = 0;
            sbq.delete(); gnt_log.delete(); pop_log.delete();
            exp_req_addr = '0;
        end else begin
            if (busy) begin
                if (rv_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word(resp_addr);
                    busy        = 1'b0;
                end else rv_cnt--;
            end else if (imem_req && gnt_budget != 0) begin
                if (gw_cnt >= gnt_lat) begin
                    imem_gnt  = 1'b1;
                    resp_addr = imem_addr;
                    busy      = 1'b1;
                    rv_cnt    = rv_lat - 1;
                    gw_cnt    = 0;
                    if (gnt_budget > 0) gnt_budget--;
                end else gw_cnt++;
            end else gw_cnt = 0;

            if (instr_valid && sbq.size() == 0) stale_cnt++;
            if (instr_valid && instr_ready) begin
                if (sbq.size() == 0) check("pop_unexpected", 1'b0, 64'(instr_pc), 64'hFFFF_FFFF);
                else begin
                    e = sbq.pop_front();
                    check("pop_pc", instr_pc == e, 64'(instr_pc), 64'(e));
                    check("pop_word", instr == word(e), 64'(instr), 64'(word(e)));
                end
                pop_log.push_back(instr_pc);
            end
            if (imem_req && imem_gnt) begin
                check("gnt_addr", imem_addr == exp_req_addr, 64'(imem_addr), 64'(exp_req_addr));
                sbq.push_back(exp_req_addr);
                gnt_log.push_back(imem_addr);
                exp_req_addr = exp_req_addr + 32'd1;
            end
            if (branch_taken) begin
                sbq.delete(); gnt_log.delete(); pop_log.delete();
                exp_req_addr = branch_target;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_branch(input logic [31:0] t);
        branch_taken  = 1'b1;
        branch_target = t;
        tick(1);
        branch_taken  = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int limit, input string name);
        for (int c = 0; c < limit && pop_log.size() < n; c++) tick(1);
        check(name, pop_log.size() >= n, 64'(pop_log.size()), 64'(n));
    endtask

    function automatic bit trig(input int mode);
        case (mode)
            0:       return imem_req && !busy && gw_cnt < gnt_lat;
            1:       return busy && rv_cnt >= 1;
            2:       return busy && rv_cnt == 0;
            3:       return imem_req && !busy && gw_cnt >= gnt_lat;
            4:       return !imem_req && !busy;
            default: return busy && rv_cnt >= 2;
        endcase
    endfunction

    typedef struct {
        int          mode;      // 0 REQ no gnt, 1 WAIT, 2 with rvalid, 3 REQ+gnt, 4 IDLE, 5 DRAIN
        int          glat;
        int          rlat;
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vt[6];
    logic [31:0] hold_pc, nxt;
    logic [INSTR_W-1:0] hold_i;
    bit          found, req_seen;
    int          n0;

    initial begin
        vt[0] = '{1, 0, 4, 32'h0000_0040, 32'h0000_0040, 32'h0000_0040};
        vt[1] = '{2, 0, 1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0100};
        vt[2] = '{0, 3, 1, 32'h0000_0200, 32'h0000_0200, 32'h0000_0200};
        vt[3] = '{3, 0, 2, 32'h0000_0300, 32'h0000_0300, 32'h0000_0300};
        vt[4] = '{4, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vt[5] = '{5, 0, 4, 32'h0000_0500, 32'h0000_0500, 32'h0000_0500};

        // reset state
        tick(3);
        check("rst_req",   imem_req == 1'b0,    64'(imem_req),    64'd0);
        check("rst_valid", instr_valid == 1'b0, 64'(instr_valid), 64'd0);
        check("rst_instr", instr == '0,         64'(instr),       64'd0);
        check("rst_pc",    instr_pc == '0,      64'(instr_pc),    64'd0);
        rst = 1'b0;

        // streaming with immediate grant
        wait_pops(4, 60, "stream_timeout");
        for (int i = 0; i < 4; i++)
            check("addr_seq", gnt_log.size() > i && gnt_log[i] == 32'(i), 64'(gnt_log[i]), 64'(i));
        for (int i = 0; i < 3; i++)
            check("pc_seq", pop_log.size() > i && pop_log[i] == 32'(i), 64'(pop_log[i]), 64'(i));

        // decoder stall
        instr_ready = 1'b0;
        tick(4);
        check("stall_valid", instr_valid == 1'b1, 64'(instr_valid), 64'd1);
        hold_i  = instr;
        hold_pc = instr_pc;
        req_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            if (c >= 2 && imem_req) req_seen = 1'b1;
        end
        check("full_no_req", !req_seen, 64'(req_seen), 64'd0);
        check("fifo_full", sbq.size() == DEPTH && !busy, 64'(sbq.size()), 64'(DEPTH));
        check("hold_instr", instr == hold_i, 64'(instr), 64'(hold_i));
        check("hold_pc", instr_pc == hold_pc, 64'(instr_pc), 64'(hold_pc));
        nxt = sbq[DEPTH-1] + 32'd1;
        n0  = gnt_log.size();
        instr_ready = 1'b1;
        for (int c = 0; c < 20 && gnt_log.size() <= n0; c++) tick(1);
        check("resume_addr", gnt_log.size() > n0 && gnt_log[n0] == nxt, 64'(gnt_log[n0]), 64'(nxt));

        // branch scenarios
        foreach (vt[k]) begin
            gnt_lat = vt[k].glat;
            rv_lat  = vt[k].rlat;
            found   = 1'b0;
            for (int c = 0; c < 100 && !found; c++) begin
                found = trig(vt[k].mode);
                if (!found) tick(1);
            end
            check("br_trigger", found, 64'(k), 64'(vt[k].mode));
            if (vt[k].mode == 5) do_branch(vt[k].target ^ 32'h100);
            do_branch(vt[k].target);
            wait_pops(1, 100, "br_timeout");
            check("br_addr", gnt_log.size() > 0 && gnt_log[0] == vt[k].exp_addr, 64'(gnt_log[0]), 64'(vt[k].exp_addr));
            check("br_pc", pop_log.size() > 0 && pop_log[0] == vt[k].exp_pc, 64'(pop_log[0]), 64'(vt[k].exp_pc));
        end

        // asynchronous reset while a request is held
        instr_ready = 1'b0;
        gnt_lat = 5;
        rv_lat  = 1;
        found   = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            found = imem_req && instr_valid && gw_cnt < gnt_lat;
            if (!found) tick(1);
        end
        check("arst_setup", found, 64'(found), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_req",   imem_req == 1'b0,    64'(imem_req),    64'd0);
        check("arst_valid", instr_valid == 1'b0, 64'(instr_valid), 64'd0);
        tick(2);
        gnt_lat = 0;
        instr_ready = 1'b1;
        rst = 1'b0;
        wait_pops(1, 60, "arst_timeout");
        check("arst_addr", gnt_log.size() > 0 && gnt_log[0] == 32'd0, 64'(gnt_log[0]), 64'd0);
        check("arst_pc", pop_log.size() > 0 && pop_log[0] == 32'd0, 64'(pop_log[0]), 64'd0);

        tick(5);
        check("no_stale_valid", stale_cnt == 0, 64'(stale_cnt), 64'd0);

`ifdef FETCH_PERF_EN
        rst = 1'b1;
        tick(2);
        gnt_budget = 5;
        rst = 1'b0;
        wait_pops(5, 100, "perf_timeout");
        do_branch(32'h80);
        tick(2);
        do_branch(32'h90);
        tick(2);
        check("perf_fetched", perf_fetched == 32'd5, 64'(perf_fetched), 64'd5);
        check("perf_flushed", perf_flushed == 32'd2, 64'(perf_flushed), 64'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
